// File: rtl/ws2812b_in_module_pkg.sv
// Shared WS2812B definitions: word width and receive FSM state encoding.
// The transmit path imports the same package.
package ws2812b_in_module_pkg;

   localparam int WS2812B_WORD_BITS = 24;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      IDLE = 2'd1,
      HIGH = 2'd2
   } rx_state_e;

endpackage

// File: rtl/ws2812b_in_module_sync.sv
// 2-FF synchronizer for the asynchronous data pin, plus single-cycle
// rise/fall strobes derived from the synchronized level.
module ws2812b_in_sync (
   input  logic clk,
   input  logic resetn,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   // [0],[1] are the synchronizer; [2] is the previous synchronized sample
   logic [2:0] sh;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) sh <= '0;
      else         sh <= {sh[1:0], din};
   end

   assign level = sh[1];
   assign rise  = sh[1] & ~sh[2];
   assign fall  = ~sh[1] & sh[2];

endmodule

// File: rtl/ws2812b_in_module.sv
// WS2812B receiver: measures high-pulse widths on the synchronized pin,
// assembles 24-bit words and hands them out over an available/read handshake.
module ws2812b_in_module
   import ws2812b_in_module_pkg::*;
#(
   parameter int CYCLES_THRESHOLD = 4,
   parameter int CYCLES_MAX_HIGH  = 15,
   parameter int CYCLES_RET       = 450
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ws2812b_din,
   input  logic        bitstream_read,
   output logic [23:0] bitstream,
   output logic        bitstream_available,
   output logic [7:0]  word_index,
   output logic        frame_done,
   output logic        err_overflow,
   output logic        err_protocol,
   output logic [3:0]  debug_info
);

   localparam int CNT_W = $clog2(CYCLES_RET + 1);
   localparam int BC_W  = $clog2(WS2812B_WORD_BITS);
   localparam logic [CNT_W-1:0] RET_C   = CNT_W'(CYCLES_RET);
   localparam logic [CNT_W-1:0] RET_M1  = CNT_W'(CYCLES_RET - 1);
   localparam logic [CNT_W-1:0] MAXH_M1 = CNT_W'(CYCLES_MAX_HIGH - 1);
   localparam logic [CNT_W-1:0] THR_C   = CNT_W'(CYCLES_THRESHOLD);
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WS2812B_WORD_BITS - 1);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic line, rise, fall;

   ws2812b_in_sync u_sync (
      .clk    (clk),
      .resetn (resetn),
      .din    (ws2812b_din),
      .level  (line),
      .rise   (rise),
      .fall   (fall)
   );

   rx_state_e                     state, state_n;
   logic [CNT_W-1:0]              low_cnt, low_n, high_cnt, high_n;
   logic [BC_W-1:0]               bit_count, bc_n;
   logic [WS2812B_WORD_BITS-2:0]  shreg, sr_n;
   logic [23:0]                   bs_n;
   logic                          av_n, fd_n, eo_n, ep_n, rx_bit;
   logic [7:0]                    wi_n;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state               <= SYNC;
         low_cnt             <= '0;
         high_cnt            <= '0;
         bit_count           <= '0;
         shreg               <= '0;
         bitstream           <= '0;
         bitstream_available <= 1'b0;
         word_index          <= '0;
         frame_done          <= 1'b0;
         err_overflow        <= 1'b0;
         err_protocol        <= 1'b0;
      end else begin
         state               <= state_n;
         low_cnt             <= low_n;
         high_cnt            <= high_n;
         bit_count           <= bc_n;
         shreg               <= sr_n;
         bitstream           <= bs_n;
         bitstream_available <= av_n;
         word_index          <= wi_n;
         frame_done          <= fd_n;
         err_overflow        <= eo_n;
         err_protocol        <= ep_n;
      end
   end

   always_comb begin
      state_n = state;
      low_n   = low_cnt;
      high_n  = high_cnt;
      bc_n    = bit_count;
      sr_n    = shreg;
      bs_n    = bitstream;
      av_n    = bitstream_available;
      wi_n    = word_index;
      fd_n    = 1'b0;
      eo_n    = 1'b0;
      ep_n    = 1'b0;
      rx_bit  = (high_cnt >= THR_C);

      if (bitstream_read && bitstream_available) av_n = 1'b0;

      case (state)
         // Wait for a full low gap; low_cnt is left saturated so IDLE
         // does not report a frame end on entry.
         SYNC: begin
            bc_n = '0;
            sr_n = '0;
            if (line) begin
               low_n = '0;
            end else if (low_cnt != RET_C) begin
               low_n = low_cnt + ONE_C;
               if (low_cnt == RET_M1) state_n = IDLE;
            end
         end
         IDLE: begin
            if (rise) begin
               state_n = HIGH;
               high_n  = ONE_C;
            end else if (low_cnt != RET_C) begin
               low_n = low_cnt + ONE_C;
               if (low_cnt == RET_M1) begin
                  fd_n = 1'b1;
                  wi_n = '0;
                  ep_n = (bit_count != '0);
                  bc_n = '0;
                  sr_n = '0;
               end
            end
         end
         HIGH: begin
            if (fall) begin
               state_n = IDLE;
               low_n   = ONE_C;
               if (bit_count == LAST_BIT) begin
                  bc_n = '0;
                  sr_n = '0;
                  // A read landing in the completion cycle frees the slot
                  if (!bitstream_available || bitstream_read) begin
                     bs_n = {shreg, rx_bit};
                     av_n = 1'b1;
                     if (word_index != 8'hFF) wi_n = word_index + 8'd1;
                  end else begin
                     eo_n = 1'b1;
                  end
               end else begin
                  bc_n = bit_count + BC_W'(1);
                  sr_n = {shreg[WS2812B_WORD_BITS-3:0], rx_bit};
               end
            end else if (high_cnt == MAXH_M1) begin
               ep_n    = 1'b1;
               bc_n    = '0;
               sr_n    = '0;
               low_n   = '0;
               state_n = SYNC;
            end else begin
               high_n = high_cnt + ONE_C;
            end
         end
         default: state_n = SYNC;
      endcase
   end

   assign debug_info = {state, (bit_count == '0), bitstream_available};

endmodule

// File: tb/tb_ws2812b_in_module.sv
// Self-checking bench for the WS2812B receiver: directed scenarios plus a
// randomized word stream checked against a word-level handshake model.
module tb_ws2812b_in_module;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        din = 1'b0;
   logic        rd = 1'b0;
   logic [23:0] bitstream;
   logic        avail;
   logic [7:0]  word_index;
   logic        frame_done, err_overflow, err_protocol;
   logic [3:0]  debug_info;

   int vec = 0;
   int errs = 0;

   // running totals, only written by the monitor
   int fd_tot = 0, eo_tot = 0, ep_tot = 0, both_tot = 0, cyc = 0, fd_cyc = 0;

   ws2812b_in_module dut (
      .clk                 (clk),
      .resetn              (resetn),
      .ws2812b_din         (din),
      .bitstream_read      (rd),
      .bitstream           (bitstream),
      .bitstream_available (avail),
      .word_index          (word_index),
      .frame_done          (frame_done),
      .err_overflow        (err_overflow),
      .err_protocol        (err_protocol),
      .debug_info          (debug_info)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (frame_done) begin
         fd_tot <= fd_tot + 1;
         fd_cyc <= cyc;
      end
      if (err_overflow) eo_tot <= eo_tot + 1;
      if (err_protocol) ep_tot <= ep_tot + 1;
      if (frame_done && err_protocol) both_tot <= both_tot + 1;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Encoding: 0 = short high / long low, 1 = long high / short low.
   task automatic send_bit(input bit b, input bit rnd);
      int h, l;
      if (rnd) begin
         h = b ? $urandom_range(12, 4) : $urandom_range(3, 2);
         l = $urandom_range(8, 2);
      end else begin
         h = b ? 5 : 3;
         l = b ? 3 : 5;
      end
      din = 1'b1;
      repeat (h) @(negedge clk);
      din = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   task automatic send_word(input logic [23:0] w, input bit rnd);
      for (int i = 23; i >= 0; i--) send_bit(w[i], rnd);
      repeat (3) @(negedge clk);
   endtask

   task automatic gap(input int n);
      din = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_read();
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      resetn = 1'b0; din = 1'b0; rd = 1'b0;
      repeat (3) @(negedge clk);
      vec++; if (bitstream !== 24'h0) begin errs++; $display("FAIL reset_bitstream: got %h want 000000", bitstream); end
      vec++; if (avail !== 1'b0) begin errs++; $display("FAIL reset_avail: got %b want 0", avail); end
      vec++; if (word_index !== 8'd0) begin errs++; $display("FAIL reset_word_index: got %0d want 0", word_index); end
      vec++; if ({frame_done, err_overflow, err_protocol} !== 3'b000) begin errs++; $display("FAIL reset_pulses: got %b want 000", {frame_done, err_overflow, err_protocol}); end
      vec++; if (debug_info !== 4'b0010) begin errs++; $display("FAIL reset_debug: got %b want 0010", debug_info); end
      resetn = 1'b1;
      gap(460);
   endtask

   task automatic test_single_word();
      int fd0, ep0, t_end;
      fd0 = fd_tot; ep0 = ep_tot;
      send_word(24'h00FF01, 1'b0);
      t_end = cyc;
      vec++; if (bitstream !== 24'h00FF01) begin errs++; $display("FAIL single_bitstream: got %h want 00ff01", bitstream); end
      vec++; if (avail !== 1'b1) begin errs++; $display("FAIL single_avail: got %b want 1", avail); end
      vec++; if (word_index !== 8'd1) begin errs++; $display("FAIL single_word_index: got %0d want 1", word_index); end
      gap(460);
      vec++; if (fd_tot - fd0 !== 1) begin errs++; $display("FAIL single_frame_done_count: got %0d want 1", fd_tot - fd0); end
      // last bit is a 1 with 3 low cycles, plus 3 trailing: fall ~6 cycles before t_end
      vec++; if ((fd_cyc - (t_end - 6)) < 445 || (fd_cyc - (t_end - 6)) > 460) begin errs++; $display("FAIL single_frame_done_time: got %0d cycles want ~451", fd_cyc - (t_end - 6)); end
      vec++; if (word_index !== 8'd0) begin errs++; $display("FAIL single_index_cleared: got %0d want 0", word_index); end
      vec++; if (avail !== 1'b1) begin errs++; $display("FAIL single_avail_survives_gap: got %b want 1", avail); end
      vec++; if (debug_info !== 4'b0111) begin errs++; $display("FAIL single_debug: got %b want 0111", debug_info); end
      vec++; if (ep_tot - ep0 !== 0) begin errs++; $display("FAIL single_no_protocol_err: got %0d want 0", ep_tot - ep0); end
   endtask

   task automatic test_overflow();
      int eo0;
      do_read();
      vec++; if (avail !== 1'b0) begin errs++; $display("FAIL read_clears_avail: got %b want 0", avail); end
      eo0 = eo_tot;
      send_word(24'hA5A5A5, 1'b0);
      send_word(24'h123456, 1'b0);
      vec++; if (eo_tot - eo0 !== 1) begin errs++; $display("FAIL overflow_count: got %0d want 1", eo_tot - eo0); end
      vec++; if (bitstream !== 24'hA5A5A5) begin errs++; $display("FAIL overflow_kept_word: got %h want a5a5a5", bitstream); end
      vec++; if (word_index !== 8'd1) begin errs++; $display("FAIL overflow_word_index: got %0d want 1", word_index); end
   endtask

   task automatic test_read_same_cycle();
      int eo0;
      logic [23:0] w;
      w = 24'h123456;
      eo0 = eo_tot;
      for (int i = 23; i >= 1; i--) send_bit(w[i], 1'b0);
      // last bit (0): read is high exactly at the completion edge
      din = 1'b1;
      repeat (3) @(negedge clk);
      din = 1'b0;
      repeat (2) @(negedge clk);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      repeat (3) @(negedge clk);
      vec++; if (bitstream !== 24'h123456) begin errs++; $display("FAIL samecycle_bitstream: got %h want 123456", bitstream); end
      vec++; if (avail !== 1'b1) begin errs++; $display("FAIL samecycle_avail: got %b want 1", avail); end
      vec++; if (eo_tot - eo0 !== 0) begin errs++; $display("FAIL samecycle_no_overflow: got %0d want 0", eo_tot - eo0); end
      vec++; if (word_index !== 8'd2) begin errs++; $display("FAIL samecycle_word_index: got %0d want 2", word_index); end
      gap(460);
   endtask

   task automatic test_partial_frame();
      int ep0, fd0, b0;
      do_read();
      ep0 = ep_tot; fd0 = fd_tot; b0 = both_tot;
      for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(1, 0)), 1'b1);
      gap(460);
      vec++; if (ep_tot - ep0 !== 1) begin errs++; $display("FAIL partial_protocol_err: got %0d want 1", ep_tot - ep0); end
      vec++; if (fd_tot - fd0 !== 1) begin errs++; $display("FAIL partial_frame_done: got %0d want 1", fd_tot - fd0); end
      vec++; if (both_tot - b0 !== 1) begin errs++; $display("FAIL partial_same_cycle: got %0d want 1", both_tot - b0); end
      vec++; if (avail !== 1'b0) begin errs++; $display("FAIL partial_avail: got %b want 0", avail); end
      send_word(24'hC3C3C3, 1'b1);
      vec++; if (bitstream !== 24'hC3C3C3 || avail !== 1'b1) begin errs++; $display("FAIL partial_next_frame: got %h/%b want c3c3c3/1", bitstream, avail); end
      gap(460);
   endtask

   task automatic test_stuck_high();
      int ep0, fd0;
      do_read();
      ep0 = ep_tot;
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      din = 1'b1;
      repeat (20) @(negedge clk);
      gap(5);
      vec++; if (ep_tot - ep0 !== 1) begin errs++; $display("FAIL stuck_protocol_err: got %0d want 1", ep_tot - ep0); end
      send_word(24'h5A5A5A, 1'b0);
      vec++; if (avail !== 1'b0) begin errs++; $display("FAIL stuck_word_ignored: got avail %b want 0", avail); end
      fd0 = fd_tot;
      gap(460);
      vec++; if (fd_tot - fd0 !== 0) begin errs++; $display("FAIL stuck_no_frame_done: got %0d want 0", fd_tot - fd0); end
      send_word(24'h0F0F0F, 1'b0);
      vec++; if (bitstream !== 24'h0F0F0F || avail !== 1'b1) begin errs++; $display("FAIL stuck_recovery: got %h/%b want 0f0f0f/1", bitstream, avail); end
      gap(460);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 11; i++) send_bit(1'($urandom_range(1, 0)), 1'b0);
      din = 1'b1;
      repeat (2) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      vec++; if (bitstream !== 24'h0 || avail !== 1'b0 || word_index !== 8'd0) begin errs++; $display("FAIL async_reset_outputs: got %h/%b/%0d want 000000/0/0", bitstream, avail, word_index); end
      vec++; if (debug_info !== 4'b0010) begin errs++; $display("FAIL async_reset_debug: got %b want 0010", debug_info); end
      @(negedge clk);
      din = 1'b0;
      resetn = 1'b1;
      gap(5);
      send_word(24'h89ABCD, 1'b0);
      vec++; if (avail !== 1'b0) begin errs++; $display("FAIL async_needs_gap: got avail %b want 0", avail); end
      gap(460);
      send_word(24'h89ABCD, 1'b0);
      vec++; if (bitstream !== 24'h89ABCD || avail !== 1'b1) begin errs++; $display("FAIL async_recovery: got %h/%b want 89abcd/1", bitstream, avail); end
      gap(460);
   endtask

   // Word-level model: a word loads only when the slot is free, else it is dropped.
   task automatic test_random();
      logic [23:0] w, m_bs;
      logic        m_av;
      int          m_wi, m_ovf, eo0, fd0;
      do_read();
      m_bs = bitstream; m_av = 1'b0; m_wi = 0; m_ovf = 0;
      eo0 = eo_tot; fd0 = fd_tot;
      for (int n = 0; n < 8; n++) begin
         if ($urandom_range(1, 0) == 1) begin
            do_read();
            m_av = 1'b0;
         end
         w = 24'($urandom);
         send_word(w, 1'b1);
         if (!m_av) begin
            m_bs = w; m_av = 1'b1; m_wi++;
         end else begin
            m_ovf++;
         end
         vec++; if (bitstream !== m_bs || avail !== m_av || word_index !== 8'(m_wi)) begin errs++; $display("FAIL random_word%0d: got %h/%b/%0d want %h/%b/%0d", n, bitstream, avail, word_index, m_bs, m_av, m_wi); end
         vec++; if (eo_tot - eo0 !== m_ovf) begin errs++; $display("FAIL random_overflow%0d: got %0d want %0d", n, eo_tot - eo0, m_ovf); end
      end
      gap(460);
      vec++; if (fd_tot - fd0 !== 1 || word_index !== 8'd0 || avail !== m_av) begin errs++; $display("FAIL random_frame_end: got fd=%0d wi=%0d av=%b want 1/0/%b", fd_tot - fd0, word_index, avail, m_av); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_overflow();
      test_read_same_cycle();
      test_partial_frame();
      test_stuck_high();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
